bcd_scan_ctrl: RTL and testbench

- Time-multiplexes NUM_DIGITS packed BCD digits through one shared BCD-to-one-hot-decimal decoder.
- Per digit: drives the decoder's 4-bit input (a = MSB … d = LSB), a decoder enable and a one-hot digit select; holds each digit for a fixed dwell, then a blanking gap.
- New frames are loaded through a valid/ready handshake and double-buffered, so updates only take effect at frame boundaries.
- Sits between the counter/arithmetic logic producing BCD values and the decimal decoder/display drivers.

---
 rtl/bcd_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// Scans NUM_DIGITS packed BCD digits through one shared decoder, with a double-buffered frame load.
// Optional build macro BCD_SCAN_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    output logic                    dec_en,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    err,
    output logic                    scan_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ?
                             ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                             ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CNT_W = $clog2(MAX_CYC);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    state_t                  state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [4*NUM_DIGITS-1:0] active_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic                    pending_reg;
    logic                    load_ready_reg;
    logic [3:0]              bcd_out_reg;
    logic                    dec_en_reg;
    logic [NUM_DIGITS-1:0]   digit_sel_reg;
    logic                    err_reg;
    logic                    scan_done_reg;

    logic                    accept;
    logic                    dwell_end;
    logic                    blank_end;
    logic                    advance;
    logic                    wrap;
    logic                    active_write;
    logic                    show_next;
    logic                    lit_next;
    logic                    pending_next;
    logic [IDX_W-1:0]        idx_next;
    logic [4*NUM_DIGITS-1:0] active_next;
    logic [3:0]              bcd_next;
    logic [NUM_DIGITS-1:0]   bad_next;
    logic [NUM_DIGITS-1:0]   nz_next;

    assign accept       = load_valid & load_ready_reg;
    assign dwell_end    = (cnt_reg == DWELL_LAST);
    assign blank_end    = (cnt_reg == BLANK_LAST);
    assign advance      = ((state_reg == DWELL) && dwell_end && (BLANK_CYCLES == 0)) ||
                          ((state_reg == BLANK) && blank_end);
    assign wrap         = advance && (idx_reg == IDX_LAST);
    assign active_write = ((state_reg == IDLE) && accept) || (wrap && pending_reg);
    assign active_next  = ((state_reg == IDLE) && accept) ? load_data :
                          (wrap && pending_reg)           ? shadow_reg : active_reg;
    assign idx_next     = (state_reg == IDLE) ? '0 :
                          advance ? (wrap ? '0 : idx_reg + 1'b1) : idx_reg;
    assign show_next    = ((state_reg == IDLE) && accept) ||
                          ((state_reg == DWELL) && !dwell_end) || advance;
    // A load taken while running lands in the shadow; a wrap only consumes what was already pending.
    assign pending_next = ((state_reg != IDLE) && accept) ? 1'b1 :
                          wrap ? 1'b0 : pending_reg;
    assign bcd_next     = active_next[4*idx_next +: 4];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign bad_next[gi] = (active_next[4*gi +: 4] > 4'd9);
            assign nz_next[gi]  = (active_next[4*gi +: 4] != 4'd0);
        end
    endgenerate

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_next;
    always_comb begin
        msd_next = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (nz_next[i]) msd_next = IDX_W'(i);
        end
    end
    assign lit_next = (idx_next <= msd_next);
`else
    logic unused_nz;
    assign unused_nz = ^nz_next;
    assign lit_next  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            load_ready_reg <= 1'b1;
            bcd_out_reg    <= '0;
            dec_en_reg     <= 1'b0;
            digit_sel_reg  <= '0;
            err_reg        <= 1'b0;
            scan_done_reg  <= 1'b0;
        end else begin
            active_reg     <= active_next;
            idx_reg        <= idx_next;
            pending_reg    <= pending_next;
            load_ready_reg <= ~pending_next;
            scan_done_reg  <= wrap;
            if ((state_reg != IDLE) && accept) shadow_reg <= load_data;
            if (active_write) err_reg <= |bad_next;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= DWELL;
                        cnt_reg   <= '0;
                    end
                end
                DWELL: begin
                    if (dwell_end) begin
                        state_reg <= (BLANK_CYCLES > 0) ? BLANK : DWELL;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_end) begin
                        state_reg <= DWELL;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Blanking keeps bcd_out so the decoder input does not glitch between digits.
            if (show_next) begin
                bcd_out_reg   <= bcd_next;
                digit_sel_reg <= lit_next ? (NUM_DIGITS'(1) << idx_next) : '0;
                dec_en_reg    <= lit_next && (bcd_next <= 4'd9);
            end else if ((state_reg == DWELL) && dwell_end) begin
                digit_sel_reg <= '0;
                dec_en_reg    <= 1'b0;
            end
        end
    end

    assign load_ready = load_ready_reg;
    assign bcd_out    = bcd_out_reg;
    assign dec_en     = dec_en_reg;
    assign digit_sel  = digit_sel_reg;
    assign err        = err_reg;
    assign scan_done  = scan_done_reg;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl: table vectors, directed corner sequences and random traffic against a frame-time model.
module tb_bcd_scan_ctrl;

    localparam int N      = 4;
    localparam int D      = 3;
    localparam int B      = 1;
    localparam int PERIOD = N * (D + B);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_data;
    logic [3:0]    bcd_out;
    logic          dec_en;
    logic [N-1:0]  digit_sel;
    logic          err;
    logic          scan_done;

    bcd_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .bcd_out(bcd_out), .dec_en(dec_en),
        .digit_sel(digit_sel), .err(err), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position within the frame as a plain cycle count.
    bit          m_run;
    int          m_t;
    logic [15:0] m_active, m_shadow;
    bit          m_pend, m_err, m_sd;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  en_mask;
        logic [3:0]  sel_mask;
        logic        err;
    } vec_t;
    vec_t vecs[7];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic bit has_bad(input logic [15:0] v);
        for (int i = 0; i < N; i++) if (((v >> (4*i)) & 16'hF) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit suppressed(input logic [15:0] v, input int slot);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        int msd = 0;
        for (int i = 1; i < N; i++) if (((v >> (4*i)) & 16'hF) != 0) msd = i;
        return slot > msd;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_model();
        int slot, phase, dig;
        bit lit;
        if (!m_run) begin
            chk("bcd_out", bcd_out, 0);
            chk("dec_en", dec_en, 0);
            chk("digit_sel", digit_sel, 0);
            chk("load_ready", load_ready, 1);
            chk("err", err, m_err);
            chk("scan_done", scan_done, 0);
        end else begin
            slot  = m_t / (D + B);
            phase = m_t % (D + B);
            dig   = int'((m_active >> (4*slot)) & 16'hF);
            lit   = (phase < D) && !suppressed(m_active, slot);
            chk("bcd_out", bcd_out, dig);
            chk("dec_en", dec_en, (lit && dig <= 9) ? 1 : 0);
            chk("digit_sel", digit_sel, lit ? (1 << slot) : 0);
            chk("load_ready", load_ready, m_pend ? 0 : 1);
            chk("err", err, m_err);
            chk("scan_done", scan_done, m_sd);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic r);
        bit acc;
        load_valid = v;
        load_data  = d;
        rst_n      = r;
        acc = v && (m_run ? !m_pend : 1'b1);
        @(posedge clk);
        m_sd = 1'b0;
        if (!r) begin
            m_run = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pend = 0; m_err = 0;
        end else if (!m_run) begin
            if (acc) begin
                m_run = 1; m_t = 0; m_active = d; m_err = has_bad(d);
            end
        end else begin
            m_t++;
            if (m_t == PERIOD) begin
                m_t  = 0;
                m_sd = 1'b1;
                if (m_pend) begin
                    m_active = m_shadow; m_pend = 0; m_err = has_bad(m_active);
                end
            end
            if (acc) begin
                m_shadow = d; m_pend = 1;
            end
        end
        #1;
        compare_model();
    endtask

    task automatic run_to(input int target);
        bit hit = 0;
        for (int i = 0; i < 2*PERIOD; i++) begin
            if (m_run && m_t == target) begin
                hit = 1;
                break;
            end
            step(1'b0, 16'h0, 1'b1);
        end
        chk("run_to_reached", hit, 1);
    endtask

    task automatic restart(input logic [15:0] d);
        step(1'b0, 16'h0, 1'b0);
        step(1'b1, d, 1'b1);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b1111, 4'b1111, 1'b0};
        vecs[1] = '{16'h12A4, 4'b1101, 4'b1111, 1'b1};
        vecs[2] = '{16'h5678, 4'b1111, 4'b1111, 1'b0};
        vecs[3] = '{16'hF000, 4'b0111, 4'b1111, 1'b1};
        vecs[6] = '{16'h9080, 4'b1111, 4'b1111, 1'b0};
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        vecs[4] = '{16'h0050, 4'b0011, 4'b0011, 1'b0};
        vecs[5] = '{16'h0000, 4'b0001, 4'b0001, 1'b0};
`else
        vecs[4] = '{16'h0050, 4'b1111, 4'b1111, 1'b0};
        vecs[5] = '{16'h0000, 4'b1111, 4'b1111, 1'b0};
`endif
        m_run = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pend = 0; m_err = 0; m_sd = 0;
        load_valid = 0; load_data = '0; rst_n = 0;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        $display("reset: load_ready=%0b digit_sel=%b", load_ready, digit_sel);

        // Table: one frame per vector, checked mid-dwell of every digit.
        for (int v = 0; v < 7; v++) begin
            restart(vecs[v].data);
            for (int t = 0; t < PERIOD; t++) begin
                if (t % (D + B) == 1) begin
                    logic [15:0] dv;
                    int s;
                    s  = t / (D + B);
                    dv = vecs[v].data;
                    chk("tbl_bcd", bcd_out, dv[4*s +: 4]);
                    chk("tbl_dec_en", dec_en, vecs[v].en_mask[s]);
                    chk("tbl_sel", digit_sel, vecs[v].sel_mask[s] ? (4'b0001 << s) : 4'b0000);
                    chk("tbl_err", err, vecs[v].err);
                end
                step(1'b0, 16'h0, 1'b1);
            end
            chk("tbl_wrap", scan_done, 1);
            $display("vector %0d: data=%h err=%0b", v, vecs[v].data, err);
        end

        // Mid-frame load is held until the wrap.
        restart(16'h1234);
        run_to(5);
        step(1'b1, 16'h9876, 1'b1);
        chk("mid_ready_low", load_ready, 0);
        chk("mid_bcd_old", bcd_out, 3);
        run_to(PERIOD - 1);
        step(1'b0, 16'h0, 1'b1);
        chk("mid_wrap_pulse", scan_done, 1);
        chk("mid_bcd_new", bcd_out, 6);
        chk("mid_ready_high", load_ready, 1);
        $display("seq mid-frame load: bcd_out=%0d after wrap", bcd_out);

        // Load coinciding with a wrap waits a full extra frame.
        restart(16'h1234);
        run_to(PERIOD - 1);
        step(1'b1, 16'h0001, 1'b1);
        chk("coin_pulse", scan_done, 1);
        chk("coin_bcd_old", bcd_out, 4);
        for (int i = 0; i < PERIOD; i++) step(1'b0, 16'h0, 1'b1);
        chk("coin_pulse2", scan_done, 1);
        chk("coin_bcd_new", bcd_out, 1);
        $display("seq wrap-coincident load: bcd_out=%0d next wrap", bcd_out);

        // err set by a non-BCD frame, cleared by the next clean frame.
        restart(16'h12A4);
        run_to(5);
        chk("err_set", err, 1);
        chk("err_slot_en", dec_en, 0);
        step(1'b1, 16'h5678, 1'b1);
        run_to(PERIOD - 1);
        step(1'b0, 16'h0, 1'b1);
        chk("err_cleared", err, 0);
        $display("seq err: err=%0b after clean frame", err);

        // Reset during digit 2 dwell returns to idle.
        restart(16'h1234);
        run_to(9);
        step(1'b0, 16'h0, 1'b0);
        chk("rst_sel", digit_sel, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_bcd", bcd_out, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
        chk("rst_idle_sel", digit_sel, 0);
        $display("seq mid-scan reset: digit_sel=%b load_ready=%0b", digit_sel, load_ready);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            for (int k = 0; k < N; k++)
                d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            step(($urandom_range(0, 9) == 0), d, ($urandom_range(0, 499) != 0));
        end
        $display("random: 3000 cycles applied");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
